// File: rtl/day1_line_parser.sv
// Streaming parser for rotation commands ("L68\n", "R30\n", ...) feeding a puzzle core.
// Emits one registered command per line; flags malformed input with a sticky error.
module day1_line_parser #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             valid,
    input  logic             ready,
    output logic             rotation,
    output logic [WIDTH-1:0] rotate_amount,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] cmd_count
);

    localparam int unsigned EW = WIDTH + 4;

    typedef enum logic [2:0] {
        DIR,
        NUM,
        EMIT,
        DONE,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       digit_cnt_q, digit_cnt_d;
    logic             last_q, last_d;
    logic             rotation_d;
    logic [WIDTH-1:0] rotate_amount_d;
    logic [WIDTH-1:0] cmd_count_d;
    logic             accept;
    logic             is_digit, is_nl, is_cr, is_l, is_r;
    logic [EW-1:0]    acc_ext;

    always_comb begin
        accept   = in_valid && in_ready;
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_nl    = (in_data == 8'h0A);
        is_cr    = (in_data == 8'h0D);
        is_l     = (in_data == 8'h4C);
        is_r     = (in_data == 8'h52);
        // Extra 4 bits let overflow be detected instead of wrapping.
        acc_ext  = ({4'b0000, acc_q} * EW'(10)) + EW'(in_data[3:0]);
    end

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        digit_cnt_d     = digit_cnt_q;
        last_d          = last_q;
        rotation_d      = rotation;
        rotate_amount_d = rotate_amount;
        cmd_count_d     = cmd_count;

        case (state_q)
            DIR: begin
                if (accept) begin
                    last_d = last_q | in_last;
                    if (is_l || is_r) begin
                        rotation_d  = is_r;
                        acc_d       = '0;
                        digit_cnt_d = '0;
                        state_d     = in_last ? ERR : NUM;
                    end else if (is_nl || is_cr) begin
                        state_d = in_last ? DONE : DIR;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            NUM: begin
                if (accept) begin
                    last_d = last_q | in_last;
                    if (is_digit) begin
                        if (acc_ext[EW-1:WIDTH] != '0) begin
                            state_d = ERR;
                        end else begin
                            acc_d       = acc_ext[WIDTH-1:0];
                            digit_cnt_d = (digit_cnt_q == '1) ? digit_cnt_q : digit_cnt_q + 4'd1;
                            state_d     = in_last ? EMIT : NUM;
                        end
                    end else if (is_cr) begin
                        if (in_last) begin
                            state_d = (digit_cnt_q != '0) ? EMIT : ERR;
                        end
                    end else if (is_nl) begin
                        state_d = (digit_cnt_q != '0) ? EMIT : ERR;
                    end else begin
                        state_d = ERR;
                    end
                end
                if (state_d == EMIT) begin
                    rotate_amount_d = acc_d;
                end
            end
            EMIT: begin
                if (ready) begin
                    cmd_count_d = cmd_count + 1'b1;
                    state_d     = last_q ? DONE : DIR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= DIR;
            acc_q         <= '0;
            digit_cnt_q   <= '0;
            last_q        <= 1'b0;
            in_ready      <= 1'b1;
            valid         <= 1'b0;
            rotation      <= 1'b0;
            rotate_amount <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            cmd_count     <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            digit_cnt_q   <= digit_cnt_d;
            last_q        <= last_d;
            // Status outputs are registered from the next state so they align with it.
            in_ready      <= (state_d == DIR) || (state_d == NUM);
            valid         <= (state_d == EMIT);
            rotation      <= rotation_d;
            rotate_amount <= rotate_amount_d;
            done          <= (state_d == DONE);
            error         <= (state_d == ERR);
            cmd_count     <= cmd_count_d;
        end
    end

endmodule

// File: tb/tb_day1_line_parser.sv
// Directed testbench for day1_line_parser with hand-computed expectations.
module tb_day1_line_parser;

    localparam int unsigned WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             valid;
    logic             ready = 1'b1;
    logic             rotation;
    logic [WIDTH-1:0] rotate_amount;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] cmd_count;

    int checks = 0;
    int errors = 0;

    logic             xfer_rot[$];
    logic [WIDTH-1:0] xfer_amt[$];
    logic             valid_seen;

    day1_line_parser #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .valid         (valid),
        .ready         (ready),
        .rotation      (rotation),
        .rotate_amount (rotate_amount),
        .done          (done),
        .error         (error),
        .cmd_count     (cmd_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) begin
            xfer_rot.delete();
            xfer_amt.delete();
            valid_seen = 1'b0;
        end else begin
            if (valid) valid_seen = 1'b1;
            if (valid && ready) begin
                xfer_rot.push_back(rotation);
                xfer_amt.push_back(rotate_amount);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_xfer(input string tag, input int idx, input logic rot, input int amt);
        if (idx < xfer_amt.size()) begin
            check({tag, "_rot"}, 32'(xfer_rot[idx]), 32'(rot));
            check({tag, "_amt"}, 32'(xfer_amt[idx]), 32'(amt));
        end else begin
            check({tag, "_present"}, xfer_amt.size(), idx + 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("handshake", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_end && (i == s.len() - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_count", 32'(cmd_count), 0);
        check("rst_amount", 32'(rotate_amount), 0);
        check("rst_rotation", 32'(rotation), 0);

        // Two commands, ready tied high, with latency checks
        ready = 1'b1;
        send_str("L68", 1'b0);
        send_byte(8'h0A, 1'b0);
        check("lat_valid", 32'(valid), 1);
        check("lat_amount", 32'(rotate_amount), 68);
        check("lat_in_ready_low", 32'(in_ready), 0);
        @(posedge clock);
        #1;
        check("lat_in_ready_back", 32'(in_ready), 1);
        send_str("R30\n", 1'b0);
        idle(3);
        check("two_nxfer", xfer_amt.size(), 2);
        check_xfer("two_0", 0, 1'b0, 68);
        check_xfer("two_1", 1, 1'b1, 30);
        check("two_count", 32'(cmd_count), 2);
        check("two_done", 32'(done), 0);

        // Back-pressure with CRLF and last on newline
        do_reset();
        ready = 1'b0;
        send_str("R5\r", 1'b0);
        send_byte(8'h0A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", 32'(valid), 1);
            check("bp_amount", 32'(rotate_amount), 5);
            check("bp_rotation", 32'(rotation), 1);
        end
        ready = 1'b1;
        idle(3);
        check("bp_nxfer", xfer_amt.size(), 1);
        check_xfer("bp_0", 0, 1'b1, 5);
        check("bp_done", 32'(done), 1);
        check("bp_count", 32'(cmd_count), 1);
        check("bp_valid_off", 32'(valid), 0);
        check("bp_in_ready_off", 32'(in_ready), 0);

        // No trailing newline
        do_reset();
        send_str("L999", 1'b1);
        idle(3);
        check("nonl_nxfer", xfer_amt.size(), 1);
        check_xfer("nonl_0", 0, 1'b0, 999);
        check("nonl_done", 32'(done), 1);
        check("nonl_error", 32'(error), 0);

        // Blank lines skipped
        do_reset();
        send_str("\n\nL1\n", 1'b0);
        idle(3);
        check("blank_nxfer", xfer_amt.size(), 1);
        check_xfer("blank_0", 0, 1'b0, 1);
        check("blank_error", 32'(error), 0);

        // Bad direction character
        do_reset();
        send_byte("X", 1'b0);
        check("badx_error", 32'(error), 1);
        check("badx_in_ready", 32'(in_ready), 0);
        idle(4);
        check("badx_valid_seen", 32'(valid_seen), 0);
        check("badx_error_sticky", 32'(error), 1);

        // Direction with no digits
        do_reset();
        send_str("L\n", 1'b0);
        idle(3);
        check("nodig_error", 32'(error), 1);
        check("nodig_nxfer", xfer_amt.size(), 0);
        check("nodig_valid_seen", 32'(valid_seen), 0);

        // Overflow at 2^WIDTH
        do_reset();
        send_str("R6553", 1'b0);
        check("ovf_pre_error", 32'(error), 0);
        send_byte("6", 1'b0);
        check("ovf_error", 32'(error), 1);
        idle(2);
        check("ovf_valid_seen", 32'(valid_seen), 0);

        // Largest representable value is accepted
        do_reset();
        send_str("L65535\n", 1'b0);
        idle(3);
        check("max_error", 32'(error), 0);
        check_xfer("max_0", 0, 1'b0, 65535);

        // Reset mid-line discards the partial command
        do_reset();
        send_str("R12", 1'b0);
        do_reset();
        send_str("L7\n", 1'b0);
        idle(3);
        check("midrst_nxfer", xfer_amt.size(), 1);
        check_xfer("midrst_0", 0, 1'b0, 7);
        check("midrst_count", 32'(cmd_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/day1_line_parser.md
DAY1_LINE_PARSER -- requirements
Module: day1_line_parser

Interface
REQ-001 Parameter: WIDTH, default 16, width of rotate_amount and cmd_count.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  ASCII byte present on in_data.
REQ-005 in_data  in  8  ASCII byte of puzzle input text.
REQ-006 in_last  in  1  qualifies in_data as final byte of file.
REQ-007 in_ready  out  1  parser accepts byte; transfer when in_valid && in_ready.
REQ-008 valid  out  1  parsed command available to puzzle core.
REQ-009 ready  in  1  puzzle core accepts command; transfer when valid && ready.
REQ-010 rotation  out  1  1 = 'R', 0 = 'L'.
REQ-011 rotate_amount  out  WIDTH  parsed decimal amount.
REQ-012 done  out  1  whole file parsed and last command transferred.
REQ-013 error  out  1  malformed input detected; sticky.
REQ-014 cmd_count  out  WIDTH  number of commands transferred.

Function
REQ-015 The block SHALL implement FSM states DIR, NUM, EMIT, DONE, ERR; reset state DIR.
REQ-016 in_ready SHALL be 1 in DIR and NUM and 0 in EMIT, DONE, ERR.
REQ-017 DIR: 'L'/'R' -> load rotation, clear accumulator and digit count, go NUM; '\n' or '\r' -> ignore (blank lines), stay; any other byte -> ERR.
REQ-018 NUM: '0'..'9' -> acc = acc*10 + digit, digit count +1; '\r' -> ignore; '\n' -> EMIT if digit count >= 1, else ERR; any other byte -> ERR.
REQ-019 Arithmetic SHALL be computed at WIDTH+4 bits; result > 2^WIDTH-1 -> ERR (no saturation, no wrap).
REQ-020 EMIT: valid = 1; rotation and rotate_amount registered and stable until transfer; on valid && ready -> DIR (or DONE if last flag set), cmd_count +1 modulo 2^WIDTH.
REQ-021 Latency: '\n' accepted in cycle N -> valid high in cycle N+1; after transfer in cycle M, in_ready high in cycle M+1.
REQ-022 in_last on an accepted byte SHALL set internal last flag; evaluated after that byte is processed: in DIR -> DONE; in NUM with digit count >= 1 (file without trailing newline) -> EMIT then DONE; in NUM with no digits -> ERR.
REQ-023 '\n' with in_last in NUM SHALL produce exactly one EMIT, then DONE.
REQ-024 DONE: done = 1, valid = 0, in_ready = 0 until reset.
REQ-025 ERR: error = 1, valid = 0, in_ready = 0 until reset; no partial command emitted.
REQ-026 in_valid low SHALL stall parsing with no state change; ready low in EMIT SHALL hold all outputs.
REQ-027 All outputs SHALL be registered; no combinational path from in_data to valid/rotation/rotate_amount.

Reset
REQ-028 reset SHALL force: state DIR, valid 0, in_ready 1 (cycle after reset deasserts), rotation 0, rotate_amount 0, done 0, error 0, cmd_count 0, accumulator, digit count and last flag 0.
REQ-029 reset asserted mid-line or during EMIT SHALL discard the partial/pending command; no transfer occurs while reset is high.

Verification
REQ-030 Bytes "L68\n" then "R30\n", ready tied 1 -> two transfers: (rotation 0, amount 68), (rotation 1, amount 30); cmd_count = 2.
REQ-031 "R5\r\n" with in_last on '\n', ready held 0 for 5 cycles -> valid high with amount 5 stable all 5 cycles, single transfer, then done = 1, cmd_count = 1.
REQ-032 "L999" with in_last on final '9', no newline -> one transfer (rotation 0, amount 999), then done = 1.
REQ-033 "\n\nL1\n" -> blank lines skipped, one transfer amount 1, error = 0.
REQ-034 Malformed "X12\n" -> error = 1 the cycle after 'X', in_ready 0, valid never asserted; "L\n" -> error, no transfer; WIDTH=16 "R65536\n" -> error on final '6'.
REQ-035 Reset asserted after "R12" (before '\n') -> no transfer; subsequent "L7\n" yields amount 7, not 127; cmd_count = 1.
